// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if -- bundle between the VGA timing generator and its
// renderer / display consumer.
//   pix_color   : renderer colour {R[2:0],G[2:0],B[1:0]} for pixel (x,y)
//   x, y        : current pixel / line counters
//   pix_tick    : last clk of each pixel period
//   video_on    : (x,y) lies in the visible area
//   frame_start : one-clk pulse on the last pixel of a frame
//   R, G, B     : registered, blanked colour (one pixel behind x/y)
//   HS, VS      : registered active-low syncs (aligned with R/G/B)
// master = timing generator, slave = renderer/display side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
   logic [7:0] pix_color;
   logic [9:0] x;
   logic [9:0] y;
   logic       pix_tick;
   logic       video_on;
   logic       frame_start;
   logic [2:0] R;
   logic [2:0] G;
   logic [1:0] B;
   logic       HS;
   logic       VS;

   modport master (
      input  pix_color,
      output x, y, pix_tick, video_on, frame_start, R, G, B, HS, VS
   );

   modport slave (
      output pix_color,
      input  x, y, pix_tick, video_on, frame_start, R, G, B, HS, VS
   );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen -- VGA raster timing generator with registered, blanked
// colour and sync outputs.
//   i_clk  : system clock (single domain, rising edge)
//   i_rst  : synchronous active-high reset
//   vga    : vga_timing_gen_if.master (pix_color in; counters, strobes,
//            colour and syncs out)
// Each pixel lasts CLK_DIV clks. x/y hold for the whole pixel; on the
// pix_tick clk the colour and syncs for the current (x,y) are registered,
// so R/G/B/HS/VS trail x/y by exactly one pixel period.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CLK_DIV = 2,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic             i_clk,
   input  logic             i_rst,
   vga_timing_gen_if.master vga
);

   localparam logic [3:0] PS_MAX   = 4'(CLK_DIV - 1);
   localparam logic [9:0] HT_M1    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VT_M1    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

   logic [3:0] r_ps;
   logic       r_tick;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic [7:0] r_rgb;
   logic       r_hs;
   logic       r_vs;

   logic       w_x_last;
   logic       w_y_last;
   logic       w_von;
   logic       w_hs_act;
   logic       w_vs_act;

   assign w_x_last = (r_x == HT_M1);
   assign w_y_last = (r_y == VT_M1);
   assign w_von    = (r_x < H_VIS_W) && (r_y < V_VIS_W);
   assign w_hs_act = (r_x >= HS_BEG) && (r_x < HS_END);
   assign w_vs_act = (r_y >= VS_BEG) && (r_y < VS_END);

   // r_ps runs one clk ahead of the pixel phase: r_tick is the registered
   // "phase == CLK_DIV-1" flag, so the first tick lands on the CLK_DIV-th
   // clk after reset release and CLK_DIV=1 gives a tick on every clk.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ps   <= '0;
         r_tick <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
         r_rgb  <= '0;
         r_hs   <= 1'b1;
         r_vs   <= 1'b1;
      end else begin
         r_ps   <= (r_ps == PS_MAX) ? 4'd0 : r_ps + 4'd1;
         r_tick <= (r_ps == PS_MAX);
         if (r_tick) begin
            r_x <= w_x_last ? 10'd0 : r_x + 10'd1;
            if (w_x_last)
               r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            // pix_color is only looked at here; blanked outside visible area
            r_rgb <= w_von ? vga.pix_color : 8'h00;
            r_hs  <= ~w_hs_act;
            r_vs  <= ~w_vs_act;
         end
      end
   end

   assign vga.x           = r_x;
   assign vga.y           = r_y;
   assign vga.pix_tick    = r_tick;
   assign vga.video_on    = w_von;
   assign vga.frame_start = r_tick & w_x_last & w_y_last;
   assign vga.R           = r_rgb[7:5];
   assign vga.G           = r_rgb[4:2];
   assign vga.B           = r_rgb[1:0];
   assign vga.HS          = r_hs;
   assign vga.VS          = r_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen -- two shrunken-raster instances (CLK_DIV=3 and 1)
// compared every clk against an arithmetic raster model: the clk index since
// reset release gives the pixel number, the pixel number gives (x,y), and the
// outputs for the previous pixel give colour and syncs.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
   localparam int HV = 16, HF = 2, H_SY = 3, HB = 4;
   localparam int VV = 8,  VF = 2, V_SY = 2, VB = 3;
   localparam int HT = HV + HF + H_SY + HB;   // 25
   localparam int VT = VV + VF + V_SY + VB;   // 15
   localparam int D0 = 3, D1 = 1;
   localparam logic [63:0] RST_EXP = {31'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if if0 ();
   vga_timing_gen_if if1 ();

   vga_timing_gen #(.CLK_DIV(D0), .H_VIS(HV), .H_FP(HF), .H_SYNC(H_SY), .H_BP(HB),
                    .V_VIS(VV), .V_FP(VF), .V_SYNC(V_SY), .V_BP(VB))
      u_dut0 (.i_clk(clk), .i_rst(rst), .vga(if0));
   vga_timing_gen #(.CLK_DIV(D1), .H_VIS(HV), .H_FP(HF), .H_SYNC(H_SY), .H_BP(HB),
                    .V_VIS(VV), .V_FP(VF), .V_SYNC(V_SY), .V_BP(VB))
      u_dut1 (.i_clk(clk), .i_rst(rst), .vga(if1));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // Expected output bundle for clk index k after release.
   function automatic logic [63:0] model(input int k, input int div, input logic [7:0] lastc);
      int p, x, y, q, qx, qy;
      logic tk, von, fs, hs, vs;
      logic [7:0] rgb;
      p   = k / div;
      tk  = ((k % div) == div - 1);
      x   = p % HT;
      y   = (p / HT) % VT;
      von = (x < HV) && (y < VV);
      fs  = tk && (x == HT - 1) && (y == VT - 1);
      rgb = 8'h00;
      hs  = 1'b1;
      vs  = 1'b1;
      if (p > 0) begin
         q   = p - 1;
         qx  = q % HT;
         qy  = (q / HT) % VT;
         rgb = ((qx < HV) && (qy < VV)) ? lastc : 8'h00;
         hs  = !((qx >= HV + HF) && (qx < HV + HF + H_SY));
         vs  = !((qy >= VV + VF) && (qy < VV + VF + V_SY));
      end
      return {31'd0, 10'(x), 10'(y), tk, von, fs, rgb, hs, vs};
   endfunction

   logic [63:0] obs0, obs1;
   assign obs0 = {31'd0, if0.x, if0.y, if0.pix_tick, if0.video_on, if0.frame_start,
                  if0.R, if0.G, if0.B, if0.HS, if0.VS};
   assign obs1 = {31'd0, if1.x, if1.y, if1.pix_tick, if1.video_on, if1.frame_start,
                  if1.R, if1.G, if1.B, if1.HS, if1.VS};

   int         k;
   logic [7:0] last0, last1;
   logic       rec;
   int         lit, hs_low;
   int         fq0[$];
   int         fq1[$];

   // One clk per iteration: check both DUTs, then drive next colour
   // (random when rnd=1, else constant FF) and remember what each DUT will
   // sample on its tick clk.
   task automatic run(input int ncyc, input bit rnd);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         chk("dut0", obs0, model(k, D0, last0));
         chk("dut1", obs1, model(k, D1, last1));
         if (rec) begin
            if (if0.frame_start) fq0.push_back(k);
            if (if1.frame_start) fq1.push_back(k);
            if ((k % D0) == D0 - 1 && (k / D0) >= 1 && (k / D0) <= HT * VT &&
                {if0.R, if0.G, if0.B} == 8'hFF) lit++;
            if (k < HT * D0 && !if0.HS) hs_low++;
         end
         if1.pix_color = 8'h00;
         if0.pix_color = rnd ? 8'($urandom) : 8'hFF;
         if1.pix_color = if0.pix_color;
         if ((k % D0) == D0 - 1) last0 = if0.pix_color;
         if ((k % D1) == D1 - 1) last1 = if1.pix_color;
         k++;
      end
   endtask

   initial begin
      if0.pix_color = 8'h00;
      if1.pix_color = 8'h00;
      last0 = 8'h00; last1 = 8'h00;
      rec = 1'b0; lit = 0; hs_low = 0; k = 0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst0", obs0, RST_EXP);
      chk("rst1", obs1, RST_EXP);
      rst = 1'b0;

      // Random colour, run dut0 into the VS and HS region (y=11, x=19)
      run(((VV + VF + 1) * HT + HV + HF + 1) * D0 + 2, 1'b1);

      // Mid-sync reset held 3 clk
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midrst0", obs0, RST_EXP);
      chk("midrst1", obs1, RST_EXP);
      rst = 1'b0;
      k = 0;
      last0 = 8'h00; last1 = 8'h00;

      // Constant white for two dut0 frames, recording strobes
      rec = 1'b1;
      run(2 * HT * VT * D0 + 5, 1'b0);

      chk("lit_pixels", 64'(lit), 64'(HV * VV));
      chk("hs_low_clk", 64'(hs_low), 64'(H_SY * D0));
      chk("fs0_count", 64'(fq0.size()), 64'd2);
      if (fq0.size() >= 1) chk("fs0_first", 64'(fq0[0]), 64'(HT * VT * D0 - 1));
      for (int i = 1; i < fq0.size(); i++)
         chk("fs0_period", 64'(fq0[i] - fq0[i-1]), 64'(HT * VT * D0));
      chk("fs1_count", 64'(fq1.size()), 64'((2 * HT * VT * D0 + 5) / (HT * VT * D1)));
      if (fq1.size() >= 1) chk("fs1_first", 64'(fq1[0]), 64'(HT * VT * D1 - 1));
      for (int i = 1; i < fq1.size(); i++)
         chk("fs1_period", 64'(fq1[i] - fq1[i-1]), 64'(HT * VT * D1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per pixel, legal range 1..16.
REQ-002 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal visible, front porch, sync and back porch widths in pixels.
REQ-003 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical visible, front porch, sync and back porch widths in lines.
REQ-004 clk  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pix_color  in  8  renderer colour {R[2:0],G[2:0],B[1:0]} for the pixel at (x,y).
REQ-007 x  out  10  current horizontal pixel counter.
REQ-008 y  out  10  current line counter.
REQ-009 pix_tick  out  1  one-clk pulse marking the last clk of each pixel period.
REQ-010 video_on  out  1  high when x<H_VIS and y<V_VIS.
REQ-011 frame_start  out  1  one-clk pulse at frame wrap.
REQ-012 R  out  3; G  out  3; B  out  2: registered, blanked pixel colour.
REQ-013 HS  out  1; VS  out  1: registered, active-low syncs.

Function
REQ-014 The prescaler shall count 0..CLK_DIV-1 and wrap; pix_tick=1 exactly when prescaler==CLK_DIV-1; for CLK_DIV=1, pix_tick shall be constantly 1 after reset.
REQ-015 x shall increment only on pix_tick cycles and wrap from HT-1 to 0, with HT=H_VIS+H_FP+H_SYNC+H_BP (800).
REQ-016 y shall increment only on pix_tick cycles where x==HT-1, wrapping from VT-1 to 0, with VT=V_VIS+V_FP+V_SYNC+V_BP (525).
REQ-017 x, y and video_on shall be stable for the whole pixel period; the renderer has CLK_DIV clk cycles to present pix_color.
REQ-018 pix_color shall be sampled only on pix_tick cycles; at any other time it shall be ignored.
REQ-019 On each pix_tick the block shall register outputs from the current (x,y): {R,G,B}=pix_color if video_on else 0.
REQ-020 On the same pix_tick, HS shall be registered as 0 iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (656..751), else 1.
REQ-021 On the same pix_tick, VS shall be registered as 0 iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (490..491), else 1.
REQ-022 R/G/B/HS/VS shall therefore lag x/y by exactly one pixel period, mutually aligned, and hold between pix_ticks.
REQ-023 frame_start shall be 1 for exactly one clk: the pix_tick cycle where x==HT-1 and y==VT-1; the next pixel is (0,0).
REQ-024 Counter widths shall be 10 bits; no counter shall exceed HT-1/VT-1, and all porch and sync comparisons shall be unsigned.

Reset
REQ-025 While rst=1 at a clk edge, the block shall set prescaler, x and y to 0; pix_tick, frame_start, R, G and B to 0; video_on to 1; HS and VS to 1.
REQ-026 Reset shall take priority over pix_tick; asserting rst mid-frame or mid-sync shall abort the frame, with no partial sync pulse after release.
REQ-027 The first pix_tick shall occur CLK_DIV clk cycles after the first edge with rst=0.

Verification
REQ-028 Defaults, reset then free-run: consecutive frame_start pulses 840000 clk apart; pix_tick period 2 clk.
REQ-029 HS check: low exactly 192 clk per line; falling edge 1 pixel after x reaches 656; line period 1600 clk.
REQ-030 VS check: low exactly 3200 clk (2 lines); falls 1 pixel after y reaches 490 with x==0.
REQ-031 Blanking: pix_color=8'hFF constant -> RGB=FF only for outputs registered at x<640, y<480; RGB=0 in all porch/sync regions; 640*480 lit pixels per frame.
REQ-032 Colour alignment: drive pix_color=x[7:0] -> on each pix_tick, registered RGB equals the previous pixel's x[7:0] within the visible area.
REQ-033 Reset mid-VS (y=491), rst held 3 clk: -> x=y=0, HS=VS=1, RGB=0 next cycle; next frame_start 840000 clk after release; CLK_DIV=1 variant repeats REQ-028 with 420000 clk.
